// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: FSM encoding and request decode shared by the SRAM arbiter.
package sram_arbiter_pkg;
  localparam int CW = 8;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_DONE_CPU
  } state_t;
  function automatic logic cpu_req_decode(input logic ce_n, input logic oe_n, input logic we_n);
    return ~ce_n & (~oe_n | ~we_n);
  endfunction
endpackage

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between the CPU data port and the read-only video fetcher.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DW             = 16,
  parameter int RD_CYCLES      = 2,
  parameter int WE_CYCLES      = 1,
  parameter int MAX_VID_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_ce_n,
  input  logic          cpu_oe_n,
  input  logic          cpu_we_n,
  input  logic [DW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          vid_req,
  input  logic [DW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  output logic          sram_ce_n,
  output logic          sram_oe_n,
  output logic          sram_we_n,
  output logic [DW-1:0] sram_addr,
  output logic [DW-1:0] sram_dout,
  output logic          sram_dout_en,
  input  logic [DW-1:0] sram_din
);
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, r_streak;
  logic            r_vid_own, r_vid_ack, r_vid_valid;
  logic [DW-1:0]   r_addr, r_dout, r_cpu_rdata, r_vid_rdata;
  logic            w_cpu_req, w_vid_grant, w_cpu_grant, w_rd_last, w_we_last;

  assign w_cpu_req   = cpu_req_decode(cpu_ce_n, cpu_oe_n, cpu_we_n);
  // video may jump a waiting CPU only until the streak limit is reached
  assign w_vid_grant = (r_state == S_IDLE) & vid_req & (~w_cpu_req | (r_streak < CW'(MAX_VID_STREAK)));
  assign w_cpu_grant = (r_state == S_IDLE) & ~w_vid_grant & w_cpu_req;
  assign w_rd_last   = r_cnt == CW'(RD_CYCLES - 1);
  assign w_we_last   = r_cnt == CW'(WE_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_streak    <= '0;
      r_vid_own   <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_vid_valid <= 1'b0;
      r_addr      <= '0;
      r_dout      <= '0;
      r_cpu_rdata <= '0;
      r_vid_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_vid_ack   <= w_vid_grant;
      r_vid_valid <= (r_state == S_RD) & w_rd_last & r_vid_own;
      if (w_vid_grant) begin
        r_addr    <= vid_addr;
        r_vid_own <= 1'b1;
        r_streak  <= w_cpu_req ? r_streak + 1'b1 : '0;
      end else if (w_cpu_grant) begin
        r_addr    <= cpu_addr;
        r_dout    <= cpu_wdata;
        r_vid_own <= 1'b0;
        r_streak  <= '0;
      end
      if ((r_state == S_RD) & w_rd_last & r_vid_own) r_vid_rdata <= sram_din;
      if ((r_state == S_RD) & w_rd_last & ~r_vid_own) r_cpu_rdata <= sram_din;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = w_vid_grant ? S_RD : w_cpu_grant ? (cpu_we_n ? S_RD : S_WR_SETUP) : S_IDLE;
      S_RD:       w_next = !w_rd_last ? S_RD : r_vid_own ? S_IDLE : S_DONE_CPU;
      S_WR_SETUP: w_next = S_WR_PULSE;
      S_WR_PULSE: w_next = w_we_last ? S_WR_HOLD : S_WR_PULSE;
      S_WR_HOLD:  w_next = S_DONE_CPU;
      S_DONE_CPU: w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_ce_n    = ~(r_state inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
    sram_oe_n    = r_state != S_RD;
    sram_we_n    = r_state != S_WR_PULSE;
    sram_dout_en = r_state inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
    cpu_stall    = w_cpu_req & (r_state != S_DONE_CPU);
  end

  assign sram_addr = r_addr;
  assign sram_dout = r_dout;
  assign cpu_rdata = r_cpu_rdata;
  assign vid_rdata = r_vid_rdata;
  assign vid_ack   = r_vid_ack;
  assign vid_valid = r_vid_valid;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed stimulus with queued expectations checked by an independent monitor.
module tb_sram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_ce_n = 1'b1, cpu_oe_n = 1'b1, cpu_we_n = 1'b1;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, vid_addr = '0;
  logic        vid_req = 1'b0;
  logic [15:0] cpu_rdata, vid_rdata, sram_addr, sram_dout, sram_din;
  logic        cpu_stall, vid_ack, vid_valid, sram_ce_n, sram_oe_n, sram_we_n, sram_dout_en;
  int          n_checks = 0, n_pass = 0;
  logic [15:0] vid_q[$], cpu_q[$], ack_q[$];
  logic [31:0] wr_q[$];

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_addr(sram_addr),
    .sram_dout(sram_dout), .sram_dout_en(sram_dout_en), .sram_din(sram_din)
  );

  always #5 clk = ~clk;

  // pad model: one planted word, every other address reads back its complement
  assign sram_din = (sram_addr == 16'h0123) ? 16'hBEEF : ~sram_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic underflow(input string name);
    n_checks++;
    $display("FAIL %s: output seen with nothing expected at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (vid_ack === 1'b1) begin
      if (ack_q.size() == 0) underflow("vid_ack");
      else chk("vid_ack_addr", sram_addr, ack_q.pop_front());
    end
    if (vid_valid === 1'b1) begin
      if (vid_q.size() == 0) underflow("vid_valid");
      else chk("vid_rdata", vid_rdata, vid_q.pop_front());
    end
    if (sram_we_n === 1'b0) begin
      if (wr_q.size() == 0) underflow("sram_we");
      else chk("wr_addr_data", {sram_addr, sram_dout}, wr_q.pop_front());
    end
    if (!cpu_ce_n && !cpu_oe_n && cpu_we_n && cpu_stall === 1'b0) begin
      if (cpu_q.size() == 0) underflow("cpu_done");
      else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (sram_dout_en === 1'b1) chk("oe_while_driving", sram_oe_n, 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cpu(input int drop_after, output int hi, output int acks);
    hi = 0;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vid_ack) begin
        acks++;
        vid_addr = vid_addr + 16'd1;
        if (acks >= drop_after) vid_req = 1'b0;
      end
      if (!cpu_stall) break;
      hi++;
    end
    step();
    cpu_ce_n = 1'b1;
    cpu_oe_n = 1'b1;
    cpu_we_n = 1'b1;
  endtask

  initial begin
    int hi, acks, got;
    cpu_ce_n = 1'b0;
    cpu_oe_n = 1'b0;
    vid_req  = 1'b1;
    vid_addr = 16'h1111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
      chk("rst_dout_en", sram_dout_en, 0);
      chk("rst_stall", cpu_stall, 1);
      chk("rst_ack_valid", {vid_ack, vid_valid}, 2'b00);
      chk("rst_addr", sram_addr, 16'h0000);
    end
    step();
    rst_n = 1'b1;
    cpu_ce_n = 1'b1;
    cpu_oe_n = 1'b1;
    vid_req = 1'b0;
    step();

    cpu_addr = 16'h0123;
    cpu_ce_n = 1'b0;
    cpu_oe_n = 1'b0;
    cpu_q.push_back(16'hBEEF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rd_ce_oe", {sram_ce_n, sram_oe_n}, (c == 1 || c == 2) ? 2'b00 : 2'b11);
      chk("rd_stall", cpu_stall, c < 3);
    end
    step();
    cpu_ce_n = 1'b1;
    cpu_oe_n = 1'b1;
    step();

    cpu_addr  = 16'h0040;
    cpu_wdata = 16'h1234;
    cpu_ce_n  = 1'b0;
    cpu_we_n  = 1'b0;
    wr_q.push_back({16'h0040, 16'h1234});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("wr_we_n", sram_we_n, c != 2);
      chk("wr_dout_en", sram_dout_en, c >= 1 && c <= 3);
      chk("wr_oe_n", sram_oe_n, 1);
      chk("wr_stall", cpu_stall, c < 4);
    end
    step();
    cpu_ce_n = 1'b1;
    cpu_we_n = 1'b1;
    step();

    vid_req  = 1'b1;
    vid_addr = 16'h8000;
    cpu_addr = 16'h0010;
    cpu_ce_n = 1'b0;
    cpu_oe_n = 1'b0;
    ack_q.push_back(16'h8000);
    vid_q.push_back(16'h7FFF);
    cpu_q.push_back(16'hFFEF);
    run_cpu(1, hi, acks);
    chk("simul_stall_cycles", hi, 6);
    chk("simul_acks", acks, 1);
    step();

    vid_req  = 1'b1;
    vid_addr = 16'h0200;
    cpu_addr = 16'h0300;
    cpu_ce_n = 1'b0;
    cpu_oe_n = 1'b0;
    ack_q = '{16'h0200, 16'h0201, 16'h0202, 16'h0203, 16'h0204};
    vid_q = '{16'hFDFF, 16'hFDFE, 16'hFDFD, 16'hFDFC, 16'hFDFB};
    cpu_q.push_back(16'hFCFF);
    run_cpu(100, hi, acks);
    chk("starve_stall_cycles", hi, 15);
    chk("starve_acks", acks, 4);
    got = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (vid_ack) begin
        got = 1;
        vid_req = 1'b0;
        break;
      end
    end
    chk("resume_ack", got, 1);
    repeat (4) @(negedge clk);
    step();

    cpu_addr  = 16'h0050;
    cpu_wdata = 16'hAAAA;
    cpu_ce_n  = 1'b0;
    cpu_we_n  = 1'b0;
    wr_q.push_back({16'h0050, 16'hAAAA});
    step();
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_we_low", sram_we_n, 0);
    @(negedge clk);
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("abort_dout_en", sram_dout_en, 0);
    chk("abort_no_done", cpu_stall, 1);
    chk("abort_rdata", cpu_rdata, 16'h0000);
    step();
    rst_n = 1'b1;
    cpu_ce_n = 1'b1;
    cpu_we_n = 1'b1;
    repeat (3) step();

    chk("vid_q_left", vid_q.size(), 0);
    chk("cpu_q_left", cpu_q.size(), 0);
    chk("ack_q_left", ack_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external async SRAM between two requesters:
  - the CPU data port, with the active-low CE/OE/WE strobes produced by the memory-map decoder;
  - the video line-fetch engine, which is read-only.
- Sequences the SRAM strobe timing for both requesters.
- Stalls the CPU while its access is pending.
- Sits between the memory-map decoder and the SRAM pads.

Parameters:
- DW, 16, data/address width (matches `DATAWIDTH).
- RD_CYCLES, 2, cycles CE_n/OE_n are held low per read; data is sampled at the end of the last one.
- WE_CYCLES, 1, cycles WE_n is held low per write.
- MAX_VID_STREAK, 4, consecutive video grants allowed while the CPU is waiting.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cpu_ce_n  in  1  CPU chip enable (active low)
- cpu_oe_n  in  1  CPU read strobe (active low)
- cpu_we_n  in  1  CPU write strobe (active low)
- cpu_addr  in  DW  CPU word address
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  CPU load data, registered
- cpu_stall  out  1  hold CPU pipeline
- vid_req  in  1  video read request (level)
- vid_addr  in  DW  video word address
- vid_ack  out  1  one-cycle pulse: request accepted, vid_addr latched
- vid_rdata  out  DW  video read data, registered
- vid_valid  out  1  one-cycle pulse: vid_rdata valid
- sram_ce_n  out  1  SRAM chip enable
- sram_oe_n  out  1  SRAM output enable
- sram_we_n  out  1  SRAM write enable
- sram_addr  out  DW  SRAM address, registered
- sram_dout  out  DW  write data to pads
- sram_dout_en  out  1  pad output-driver enable
- sram_din  in  DW  read data from pads

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-low on rst_n.
  - On reset: state IDLE; all sram_*_n = 1; sram_dout_en = 0; sram_addr = 0; sram_dout = 0; cpu_rdata = 0; vid_rdata = 0; vid_ack = 0; vid_valid = 0; streak = 0.
  - Reset asserted mid-access aborts the access at the next edge. No done or valid pulse is emitted.
- CPU request decode: cpu_req = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n).
  - cpu_we_n low wins over cpu_oe_n, making the access a write.
- cpu_stall = cpu_req & ~cpu_done, where cpu_done is registered high only in state DONE_CPU.
  - The CPU holds its request stable until it sees stall low.
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE_CPU.
- IDLE arbitration, evaluated each cycle:
  - Video is granted when vid_req = 1 and (cpu_req = 0 or streak < MAX_VID_STREAK). On grant: vid_ack = 1 next cycle, streak++ if cpu_req, else streak = 0.
  - Otherwise the CPU is granted when cpu_req = 1; streak = 0.
  - The grant latches address, data and owner into registers.
- RD: sram_ce_n = 0 and sram_oe_n = 0 for RD_CYCLES cycles.
  - sram_din is captured on the last cycle's edge into cpu_rdata or vid_rdata.
  - Video owner: vid_valid pulses the next cycle and the FSM returns to IDLE.
  - CPU owner: the FSM goes to DONE_CPU.
- WR sequence (CPU only):
  - WR_SETUP, 1 cycle: ce_n = 0, we_n = 1, dout_en = 1.
  - WR_PULSE, WE_CYCLES cycles: we_n = 0.
  - WR_HOLD, 1 cycle: we_n = 1; data and address still driven.
  - Then DONE_CPU.
- sram_oe_n is never low while sram_dout_en = 1.
- DONE_CPU: all strobes high; lasts 1 cycle, then IDLE.
  - A CPU request seen in DONE_CPU is not arbitrated; it is the completing request.
- CPU read latency, idle arbiter, RD_CYCLES = 2:
  - request in cycle 0 → stall high in cycles 0–2;
  - stall low with cpu_rdata valid in cycle 3.
- CPU write, WE_CYCLES = 1: stall high in cycles 0–3, low in cycle 4.
- Simultaneous cpu_req and vid_req in IDLE with streak = 0: video wins.
- An access in progress is never pre-empted.
- vid_req dropped before vid_ack: no access. vid_req dropped after vid_ack: the access completes.

Decomposition:
- DW-related widths and the FSM state encodings go as `defines in defines.v, alongside `DATAWIDTH.
- Single module. The arbitration pick is small enough to stay inline; no sub-module.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with cpu_req and vid_req active → all strobes 1, dout_en = 0, stall = 1, no ack.
- CPU read, addr 0x0123, sram_din = 0xBEEF → ce_n/oe_n low in cycles 1–2; stall low in cycle 3; cpu_rdata = 0xBEEF.
- CPU write, addr 0x0040, data 0x1234 → setup/pulse/hold with we_n low exactly 1 cycle; dout_en high 3 cycles; oe_n stays 1; stall low in cycle 4.
- Simultaneous requests: vid 0x8000 and CPU read 0x0010 → video first (vid_ack, then vid_valid), then CPU; CPU stall covers both accesses.
- Starvation: vid_req held high with CPU read pending → exactly 4 vid_ack pulses, then the CPU access, then video resumes.
- Reset mid-write: rst_n = 0 during WR_PULSE → next edge we_n = 1, dout_en = 0, IDLE; no done pulse.
